// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared core constants for the fetch stage
package fetch_stage_pkg;
   localparam int CORE_XLEN = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with reset/flush/load/hold priority
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            load_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   input  logic [31:0]     instr_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic [31:0]     instr_o,
   output logic            valid_o
);
   logic [XLEN-1:0] pc_q, pc_plus4_q;
   logic [31:0]     instr_q;
   logic            valid_q;
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         pc_q       <= '0;
         pc_plus4_q <= '0;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else if (load_i) begin
         pc_q       <= pc_i;
         pc_plus4_q <= pc_plus4_i;
         instr_q    <= instr_i;
         valid_q    <= 1'b1;
      end
   end
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign instr_o    = instr_q;
   assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select and IF/ID register of the RISC-V core
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN     = CORE_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCUpdateEnable,
   input  logic            IF_ID_UpdateEnable,
   input  logic            branchTaken,
   input  logic [XLEN-1:0] branchTarget,
   output logic [XLEN-1:0] imemAddr,
   input  logic [31:0]     imemData,
   output logic [XLEN-1:0] pc_IF_ID,
   output logic [XLEN-1:0] pcPlus4_IF_ID,
   output logic [31:0]     instr_IF_ID,
   output logic            valid_IF_ID
);
   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic            unused_tgt_lsbs;
   assign unused_tgt_lsbs = ^branchTarget[1:0];
   assign pc_plus4 = pc_q + XLEN'(4);
   // Redirect beats the stall enable: the branch in EX is older than the stalled pair
   always_comb pc_d = branchTaken ? {branchTarget[XLEN-1:2], 2'b00} : PCUpdateEnable ? pc_plus4 : pc_q;
   always_ff @(posedge clk) pc_q <= rst ? RESET_PC : pc_d;
   assign imemAddr = pc_q;
   if_id_reg #(.XLEN(XLEN)) u_if_id (
      .clk       (clk),
      .rst       (rst),
      .flush_i   (branchTaken),
      .load_i    (IF_ID_UpdateEnable),
      .pc_i      (pc_q),
      .pc_plus4_i(pc_plus4),
      .instr_i   (imemData),
      .pc_o      (pc_IF_ID),
      .pc_plus4_o(pcPlus4_IF_ID),
      .instr_o   (instr_IF_ID),
      .valid_o   (valid_IF_ID)
   );
endmodule
